// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/gnt + rvalid bus,
// buffers them in a small FIFO and hands {instr, instr_pc} to the decoder.
// Redirects from execute flush the buffer and discard the in-flight response.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misaligned,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    RESP  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        pc;
  logic [31:0]        req_pc;
  logic [31:0]        fifo_instr [FIFO_DEPTH];
  logic [31:0]        fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  state_t             state_next;
  logic [31:0]        pc_next;
  logic [31:0]        req_pc_next;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_next;
  logic [CNT_W-1:0]   count_next;
  logic [CNT_W-1:0]   remaining;
  logic [31:0]        head_instr;
  logic [31:0]        head_pc;
  logic               granted;
  logic               push;
  logic               pop;
  logic               req_next;
  logic               misaligned_next;

  // Next-state, FIFO bookkeeping and next head entry for the registered outputs
  always_comb begin
    granted         = imem_req && imem_gnt;
    // A redirect cancels any same-cycle push or pop: the buffer is flushed anyway.
    push            = (state == RESP) && imem_rvalid && !redirect_valid;
    pop             = instr_valid && instr_ready && !redirect_valid;
    state_next      = state;
    pc_next         = pc;
    req_pc_next     = req_pc;
    misaligned_next = redirect_valid && (redirect_pc[1:0] != 2'b00);

    case (state)
      REQ: begin
        if (redirect_valid) begin
          // A grant in the redirect cycle belongs to the old path; its data must be drained.
          state_next = granted ? DRAIN : REQ;
        end else if (granted) begin
          state_next  = RESP;
          pc_next     = pc + 32'd4;
          req_pc_next = pc;
        end else begin
          state_next = REQ;
        end
      end
      RESP: begin
        if (imem_rvalid) begin
          state_next = REQ;
        end else if (redirect_valid) begin
          state_next = DRAIN;
        end else begin
          state_next = RESP;
        end
      end
      DRAIN: begin
        // The single outstanding response is the one being drained, even if a
        // further redirect lands in the same cycle, so rvalid always ends DRAIN.
        if (imem_rvalid) begin
          state_next = REQ;
        end else begin
          state_next = DRAIN;
        end
      end
      default: begin
        state_next = REQ;
      end
    endcase

    if (redirect_valid) begin
      pc_next     = {redirect_pc[31:2], 2'b00};
      rd_ptr_next = {PTR_W{1'b0}};
      wr_ptr_next = {PTR_W{1'b0}};
      count_next  = {CNT_W{1'b0}};
    end else begin
      rd_ptr_next = rd_ptr + PTR_W'(pop);
      wr_ptr_next = wr_ptr + PTR_W'(push);
      count_next  = count + CNT_W'(push) - CNT_W'(pop);
    end

    // When the buffer would otherwise be empty, the pushed word becomes the head directly.
    remaining = count - CNT_W'(pop);
    if (push && (remaining == {CNT_W{1'b0}})) begin
      head_instr = imem_rdata;
      head_pc    = req_pc;
    end else begin
      head_instr = fifo_instr[rd_ptr_next];
      head_pc    = fifo_pc[rd_ptr_next];
    end

    // Credit rule: in REQ nothing is outstanding, so one free slot is enough to ask.
    req_next = (state_next == REQ) && (count_next < DEPTH_C);
  end

  // Fetch FSM, PC, FIFO storage and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ;
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      rd_ptr      <= {PTR_W{1'b0}};
      wr_ptr      <= {PTR_W{1'b0}};
      count       <= {CNT_W{1'b0}};
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0000_0000;
      instr_pc    <= 32'h0000_0000;
      misaligned  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= 32'h0000_0000;
        fifo_pc[i]    <= 32'h0000_0000;
      end
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      req_pc      <= req_pc_next;
      rd_ptr      <= rd_ptr_next;
      wr_ptr      <= wr_ptr_next;
      count       <= count_next;
      imem_req    <= req_next;
      imem_addr   <= pc_next;
      misaligned  <= misaligned_next;
      instr_valid <= (count_next != {CNT_W{1'b0}});
      if (push) begin
        fifo_instr[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]    <= req_pc;
      end
      // Head registers only move when there is a valid entry to show.
      if (count_next != {CNT_W{1'b0}}) begin
        instr    <= head_instr;
        instr_pc <= head_pc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit with a 1-cycle
// gnt/rvalid memory model whose response can be held back on demand.
module tb_instruction_fetch_unit;

  localparam logic [31:0] KEY = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misaligned;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int          checks = 0;
  int          errors = 0;
  logic        rv_hold = 1'b0;
  logic        pending = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] gnt_log [$];
  logic [31:0] cons    [$];

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misaligned     (misaligned),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req),    32'd0);
    check({tag, "_addr"},  imem_addr,        32'h0000_0000);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr,            32'h0000_0000);
    check({tag, "_ipc"},   instr_pc,         32'h0000_0000);
    check({tag, "_mis"},   32'(misaligned),  32'd0);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) break;
    end
    check(tag, 32'(imem_req), 32'd1);
  endtask

  // Memory model: 1-cycle grant, response one cycle after grant unless held
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pending     = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end else begin
        imem_rvalid = pending && !rv_hold;
        imem_rdata  = imem_rvalid ? (paddr ^ KEY) : 32'h0;
        if (imem_rvalid) pending = 1'b0;
        imem_gnt = imem_req && !pending;
        if (imem_gnt) begin
          pending = 1'b1;
          paddr   = imem_addr;
          gnt_log.push_back(imem_addr);
        end
      end
    end
  end

  // Consumption monitor: logs every handshake and checks the word matches its address
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && instr_valid && instr_ready) begin
        cons.push_back(instr_pc);
        check("data", instr, instr_pc ^ KEY);
      end
    end
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    cycles(3);
    check_reset_outputs("rst");

    // Test 1: fetch 0,4,8 with ready=1
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_req",  32'(imem_req), 32'd1);
    check("t1_addr", imem_addr,     32'h0000_0000);
    cycles(2);
    check("t1_v0",   32'(instr_valid), 32'd1);
    check("t1_pc0",  instr_pc,         32'h0000_0000);
    check("t1_i0",   instr,            32'h0000_0000 ^ KEY);
    cycles(1);
    check("t1_gap",  32'(instr_valid), 32'd0);
    cycles(1);
    check("t1_pc1",  instr_pc,         32'h0000_0004);
    cycles(2);
    check("t1_v2",   32'(instr_valid), 32'd1);
    check("t1_pc2",  instr_pc,         32'h0000_0008);

    // Test 2: back-pressure fills the buffer, then drain resumes fetching
    instr_ready = 1'b0;
    cycles(10);
    check("t2_req",   32'(imem_req),       32'd0);
    check("t2_ngnt",  32'(gnt_log.size()), 32'd4);
    check("t2_head",  instr_pc,            32'h0000_0008);
    cycles(2);
    check("t2_hold",  instr_pc,            32'h0000_0008);
    check("t2_holdi", instr,               32'h0000_0008 ^ KEY);
    instr_ready = 1'b1;
    cycles(12);
    check("t2_count", 32'(cons.size() >= 6), 32'd1);
    for (int i = 0; i < cons.size(); i++) check("t2_seq", cons[i], 32'(i * 4));

    // Test 3: redirect while waiting for the response
    wait_req("t3_wait");
    rv_hold = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    cons.delete();
    check("t3_flush", 32'(instr_valid), 32'd0);
    check("t3_noreq", 32'(imem_req),    32'd0);
    check("t3_mis",   32'(misaligned),  32'd0);
    @(negedge clk);
    rv_hold = 1'b0;
    @(negedge clk);
    check("t3_req",   32'(imem_req), 32'd1);
    check("t3_addr",  imem_addr,     32'h0000_0100);
    cycles(2);
    check("t3_valid", 32'(instr_valid), 32'd1);
    check("t3_pc",    instr_pc,         32'h0000_0100);
    @(negedge clk);
    check("t3_first", q_at(cons, 0), 32'h0000_0100);

    // Test 4: redirect with a full buffer and a simultaneous pop
    instr_ready = 1'b0;
    cycles(8);
    check("t4_full",  32'(instr_valid && !imem_req), 32'd1);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    @(negedge clk);
    redirect_valid = 1'b0;
    cons.delete();
    check("t4_flush", 32'(instr_valid), 32'd0);
    check("t4_req",   32'(imem_req),    32'd1);
    check("t4_addr",  imem_addr,        32'h0000_0400);
    cycles(2);
    check("t4_valid", 32'(instr_valid), 32'd1);
    check("t4_pc",    instr_pc,         32'h0000_0400);
    cycles(4);
    check("t4_c0",    q_at(cons, 0),    32'h0000_0400);
    check("t4_c1",    q_at(cons, 1),    32'h0000_0404);

    // Test 5: misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    @(negedge clk);
    redirect_valid = 1'b0;
    gnt_log.delete();
    cons.delete();
    check("t5_mis1",  32'(misaligned), 32'd1);
    @(negedge clk);
    check("t5_mis0",  32'(misaligned), 32'd0);
    cycles(8);
    check("t5_gnt",   q_at(gnt_log, 0), 32'h0000_0200);
    check("t5_cons",  q_at(cons, 0),    32'h0000_0200);

    // Test 6: asynchronous reset while a response is outstanding and one entry is buffered
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    gnt_log.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (gnt_log.size() >= 2) break;
    end
    check("t6_gnts",  q_at(gnt_log, 1), 32'h0000_0304);
    @(negedge clk);
    check("t6_valid", 32'(instr_valid), 32'd1);
    check("t6_pc",    instr_pc,         32'h0000_0300);
    check("t6_resp",  32'(imem_req),    32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    cycles(2);
    gnt_log.delete();
    cons.delete();
    instr_ready = 1'b1;
    rst_n       = 1'b1;
    cycles(6);
    check("t6_gnt0",  q_at(gnt_log, 0), 32'h0000_0000);
    check("t6_cons0", q_at(cons, 0),    32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
